// File: rtl/pred_stab_pkg.sv
// Shared types and constants for the prediction stabilizer: FSM state encoding,
// default lock length and the seven-segment pattern table.
package pred_stab_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam int          STABLE_CNT_DEFAULT = 4;
    localparam logic [3:0]  MAX_CLASS          = 4'd9;
    localparam logic [3:0]  RUN_MAX            = 4'd15;

    // Entry [n] is the a..g pattern (bit0=a) for digit n; listed 9 down to 0.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
        7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg7_decode.sv
// Purely combinational digit-to-segment decode; blank while no class is valid.
module seg7_decode
    import pred_stab_pkg::*;
(
    input  logic [3:0] i_class,
    input  logic       i_valid,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = 7'h00;
        if (i_valid && (i_class <= MAX_CLASS)) begin
            o_seg = SEG_TABLE[i_class];
        end
    end

endmodule

// File: rtl/pred_stabilizer.sv
// Debounces a stream of digit-classifier predictions: a class is only reported
// once it has been seen STABLE_CNT consecutive valid samples in a row.
module pred_stabilizer
    import pred_stab_pkg::*;
#(
    parameter int STABLE_CNT = STABLE_CNT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] pred_in,
    input  logic       pred_valid,
    input  logic       clear,
    output logic [3:0] class_out,
    output logic       class_valid,
    output logic       class_change,
    output logic [6:0] seg_out,
    output logic [3:0] run_len,
    output logic       err_sticky
);

    localparam logic [3:0] LOCK_LEN = 4'(STABLE_CNT);

    state_t     r_state;
    logic [3:0] r_cand;
    logic [3:0] r_run_len;
    logic [3:0] r_class_out;
    logic       r_class_valid;
    logic       r_class_change;
    logic       r_err_sticky;

    state_t     w_state_next;
    logic [3:0] w_cand_next;
    logic [3:0] w_run_len_next;
    logic [3:0] w_class_out_next;
    logic       w_class_valid_next;
    logic       w_class_change_next;
    logic       w_err_sticky_next;
    logic [3:0] w_run_inc;
    logic       w_match;
    logic [6:0] w_seg;

    assign w_run_inc = r_run_len + 4'd1;
    assign w_match   = (pred_in == r_cand);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_cand         <= 4'd0;
            r_run_len      <= 4'd0;
            r_class_out    <= 4'd0;
            r_class_valid  <= 1'b0;
            r_class_change <= 1'b0;
            r_err_sticky   <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_cand         <= w_cand_next;
            r_run_len      <= w_run_len_next;
            r_class_out    <= w_class_out_next;
            r_class_valid  <= w_class_valid_next;
            r_class_change <= w_class_change_next;
            r_err_sticky   <= w_err_sticky_next;
        end
    end

    always_comb begin
        w_state_next        = r_state;
        w_cand_next         = r_cand;
        w_run_len_next      = r_run_len;
        w_class_out_next    = r_class_out;
        w_class_valid_next  = r_class_valid;
        w_class_change_next = 1'b0;
        w_err_sticky_next   = r_err_sticky;

        if (clear) begin
            w_state_next       = ST_IDLE;
            w_cand_next        = 4'd0;
            w_run_len_next     = 4'd0;
            w_class_out_next   = 4'd0;
            w_class_valid_next = 1'b0;
            w_err_sticky_next  = 1'b0;
        end else if (pred_valid) begin
            if (pred_in > MAX_CLASS) begin
                // Illegal class: drop the run but keep reporting the last lock.
                w_err_sticky_next = 1'b1;
                w_run_len_next    = 4'd0;
                w_state_next      = ST_IDLE;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        w_cand_next    = pred_in;
                        w_run_len_next = 4'd1;
                        w_state_next   = ST_TRACK;
                    end
                    ST_TRACK: begin
                        if (w_match) begin
                            w_run_len_next = w_run_inc;
                            if (w_run_inc == LOCK_LEN) begin
                                w_state_next        = ST_LOCKED;
                                w_class_out_next    = r_cand;
                                w_class_valid_next  = 1'b1;
                                w_class_change_next = !r_class_valid || (r_cand != r_class_out);
                            end
                        end else begin
                            w_cand_next    = pred_in;
                            w_run_len_next = 4'd1;
                        end
                    end
                    ST_LOCKED: begin
                        if (w_match) begin
                            if (r_run_len != RUN_MAX) begin
                                w_run_len_next = w_run_inc;
                            end
                        end else begin
                            w_cand_next    = pred_in;
                            w_run_len_next = 4'd1;
                            w_state_next   = ST_TRACK;
                        end
                    end
                    default: begin
                        w_state_next = ST_IDLE;
                    end
                endcase
            end
        end
    end

    seg7_decode u_seg7_decode (
        .i_class (r_class_out),
        .i_valid (r_class_valid),
        .o_seg   (w_seg)
    );

    assign class_out    = r_class_out;
    assign class_valid  = r_class_valid;
    assign class_change = r_class_change;
    assign seg_out      = w_seg;
    assign run_len      = r_run_len;
    assign err_sticky   = r_err_sticky;

endmodule

// File: tb/tb_pred_stabilizer.sv
// Directed scenarios plus a random run, every cycle compared against a
// run-length reference model of the stabilizer.
module tb_pred_stabilizer;

    localparam int SC = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] pred_in;
    logic       pred_valid;
    logic       clear;
    logic [3:0] class_out;
    logic       class_valid;
    logic       class_change;
    logic [6:0] seg_out;
    logic [3:0] run_len;
    logic       err_sticky;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: run length 0 means "no candidate", lock happens when a
    // run first reaches SC.
    int m_cand, m_run, m_class;
    bit m_valid, m_change, m_err;
    logic [6:0] seg_ref [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    pred_stabilizer #(.STABLE_CNT(SC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pred_in      (pred_in),
        .pred_valid   (pred_valid),
        .clear        (clear),
        .class_out    (class_out),
        .class_valid  (class_valid),
        .class_change (class_change),
        .seg_out      (seg_out),
        .run_len      (run_len),
        .err_sticky   (err_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cand = 0; m_run = 0; m_class = 0;
        m_valid = 0; m_change = 0; m_err = 0;
    endtask

    task automatic model_edge(input bit v, input int p, input bit clr);
        int old;
        m_change = 0;
        if (clr) begin
            model_reset();
        end else if (v) begin
            if (p > 9) begin
                m_err = 1;
                m_run = 0;
            end else if (m_run > 0 && p == m_cand) begin
                old = m_run;
                if (m_run < 15) m_run++;
                if (old == SC - 1) begin
                    m_change = !m_valid || (m_class != m_cand);
                    m_class  = m_cand;
                    m_valid  = 1;
                end
            end else begin
                m_cand = p;
                m_run  = 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [6:0] seg_exp;
        seg_exp = m_valid ? seg_ref[m_class] : 7'h00;
        chk({tag, ".class_out"},    8'(class_out),    8'(m_class));
        chk({tag, ".class_valid"},  8'(class_valid),  8'(m_valid));
        chk({tag, ".class_change"}, 8'(class_change), 8'(m_change));
        chk({tag, ".seg_out"},      8'(seg_out),      8'(seg_exp));
        chk({tag, ".run_len"},      8'(run_len),      8'(m_run));
        chk({tag, ".err_sticky"},   8'(err_sticky),   8'(m_err));
    endtask

    task automatic step(input string tag, input bit v, input int p, input bit clr);
        pred_valid = v;
        pred_in    = 4'(p);
        clear      = clr;
        @(posedge clk);
        model_edge(v, p, clr);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("rst_async");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        int p;
        bit v, c;
        rst_n = 1'b1; pred_in = 4'd0; pred_valid = 1'b0; clear = 1'b0;
        #2;
        do_reset();
        check_all("reset");

        // Basic lock on 3
        for (int i = 0; i < 4; i++) step("lock3", 1, 3, 0);
        chk("lock3.seg_const", 8'(seg_out), 8'h4F);
        step("lock3.pulse_end", 0, 0, 0);

        // 5,5,5 then 7 x4
        for (int i = 0; i < 3; i++) step("seq5", 1, 5, 0);
        step("seq7.first", 1, 7, 0);
        chk("seq7.run_is_1", 8'(run_len), 8'd1);
        for (int i = 0; i < 3; i++) step("seq7", 1, 7, 0);
        chk("seq7.locked", 8'(class_out), 8'd7);

        // Lock on 2, excursion to 8, relock to 2 without a pulse
        for (int i = 0; i < 4; i++) step("lock2", 1, 2, 0);
        for (int i = 0; i < 3; i++) step("exc8", 1, 8, 0);
        for (int i = 0; i < 4; i++) step("relock2", 1, 2, 0);
        chk("relock2.no_pulse", 8'(class_change), 8'd0);

        // Lock on 6 then an illegal sample
        for (int i = 0; i < 4; i++) step("lock6", 1, 6, 0);
        step("illegal12", 1, 12, 0);
        chk("illegal12.seg_const", 8'(seg_out), 8'h7D);

        // Idle gap does not break a run
        step("gap", 1, 4, 0); step("gap", 1, 4, 0);
        for (int i = 0; i < 5; i++) step("gap.idle", 0, 9, 0);
        chk("gap.run_held", 8'(run_len), 8'd2);
        step("gap", 1, 4, 0); step("gap", 1, 4, 0);
        chk("gap.locked4", 8'(class_out), 8'd4);

        // Reset mid-TRACK, then full relock required
        step("pre_rst", 1, 1, 0); step("pre_rst", 1, 1, 0);
        do_reset();
        for (int i = 0; i < 4; i++) step("post_rst", 1, 1, 0);

        // Saturation, then clear while LOCKED overrides the sample
        for (int i = 0; i < 20; i++) step("sat", 1, 9, 0);
        chk("sat.run15", 8'(run_len), 8'd15);
        step("clear", 1, 9, 1);

        // Random stimulus, biased toward repeats so locks actually happen
        p = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) p = (($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9));
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 49) == 0);
            step("rand", v, p, c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
